// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmit-channel bundle for uart_tx_arbiter.
// master = arbiter view; slave = requesters plus uart_string_handle view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int STR_W   = 1024
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*STR_W-1:0] req_string;
    logic [NUM_REQ*8-1:0]     req_length;
    logic [NUM_REQ-1:0]       ack;
    logic [NUM_REQ-1:0]       done;
    logic [NUM_REQ-1:0]       err;
    logic [STR_W-1:0]         tx_string;
    logic [7:0]               tx_length;
    logic                     tx_req;
    logic                     tx_busy;
    logic                     tx_done;

    modport master (
        input  req, req_string, req_length, tx_busy, tx_done,
        output ack, done, err, tx_string, tx_length, tx_req
    );

    modport slave (
        output req, req_string, req_length, tx_busy, tx_done,
        input  ack, done, err, tx_string, tx_length, tx_req
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_string_handle channel; ack 1 cycle after req, tx_req 1 cycle later.
// Holds in ISSUE while tx_busy; optional CR/LF append under macro UART_TX_ARB_APPEND_CRLF_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int STR_W       = 1024,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_n_i,
    uart_tx_arbiter_if.master    bus,
    output logic [2:0]           grant_id_o,
    output logic                 arb_busy_o
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [2:0]         grant_q, grant_d;
    logic [STR_W-1:0]   str_q, str_d;
    logic [7:0]         len_q, len_d;
    logic [31:0]        wd_q, wd_d;
    logic               tx_req_q, tx_req_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic               ovf_q, ovf_d;

    logic               win_vld;
    logic [2:0]         win_id;
    logic [3:0]         idx;
    logic [7:0]         req8;
    logic [STR_W-1:0]   sel_str, lat_str;
    logic [7:0]         sel_len, lat_len;
    logic               lat_ovf;
    logic               wd_expire;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] id);
        onehot = NUM_REQ'(1) << id;
    endfunction

    function automatic logic [2:0] next_ptr(input logic [2:0] id);
        next_ptr = (id == 3'(NUM_REQ - 1)) ? 3'd0 : id + 3'd1;
    endfunction

    assign req8 = 8'(bus.req);

    // First set request at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_id  = 3'd0;
        idx     = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_q} + 4'(i);
            if (idx >= 4'(NUM_REQ)) idx = idx - 4'(NUM_REQ);
            if (!win_vld && req8[idx[2:0]]) begin
                win_vld = 1'b1;
                win_id  = idx[2:0];
            end
        end
    end

    always_comb begin
        sel_str = '0;
        sel_len = 8'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_id == 3'(j)) begin
                sel_str = bus.req_string[j*STR_W +: STR_W];
                sel_len = bus.req_length[j*8 +: 8];
            end
        end
    end

`ifdef UART_TX_ARB_APPEND_CRLF_EN
    localparam int NBYTES = STR_W / 8;

    // Strings too long to take CR/LF go out unchanged but are flagged with err at completion.
    always_comb begin
        lat_str = sel_str;
        lat_len = sel_len;
        lat_ovf = 1'b0;
        if (int'(sel_len) > NBYTES - 2) begin
            lat_ovf = 1'b1;
        end else begin
            for (int b = 0; b < NBYTES; b++) begin
                if (b == int'(sel_len))     lat_str[b*8 +: 8] = 8'h0D;
                if (b == int'(sel_len) + 1) lat_str[b*8 +: 8] = 8'h0A;
            end
            lat_len = sel_len + 8'd2;
        end
    end
`else
    always_comb begin
        lat_str = sel_str;
        lat_len = sel_len;
        lat_ovf = 1'b0;
    end
`endif

    assign wd_expire = (TIMEOUT_CYC != 0) && (wd_q == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        str_d    = str_q;
        len_d    = len_q;
        wd_d     = wd_q;
        ovf_d    = ovf_q;
        tx_req_d = 1'b0;
        ack_d    = '0;
        done_d   = '0;
        err_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    ack_d   = onehot(win_id);
                    grant_d = win_id;
                    if (sel_len == 8'd0) begin
                        done_d = onehot(win_id);
                        rr_d   = next_ptr(win_id);
                    end else begin
                        str_d   = lat_str;
                        len_d   = lat_len;
                        ovf_d   = lat_ovf;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!bus.tx_busy) begin
                    tx_req_d = 1'b1;
                    wd_d     = 32'd0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // tx_done takes priority over a watchdog expiring on the same cycle.
                if (bus.tx_done) begin
                    done_d  = onehot(grant_q);
                    err_d   = ovf_q ? onehot(grant_q) : '0;
                    rr_d    = next_ptr(grant_q);
                    state_d = S_IDLE;
                end else if (wd_expire) begin
                    err_d   = onehot(grant_q);
                    rr_d    = next_ptr(grant_q);
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q  <= S_IDLE;
            rr_q     <= 3'd0;
            grant_q  <= 3'd0;
            str_q    <= '0;
            len_q    <= 8'd0;
            wd_q     <= 32'd0;
            ovf_q    <= 1'b0;
            tx_req_q <= 1'b0;
            ack_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            str_q    <= str_d;
            len_q    <= len_d;
            wd_q     <= wd_d;
            ovf_q    <= ovf_d;
            tx_req_q <= tx_req_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.tx_string = str_q;
    assign bus.tx_length = len_q;
    assign bus.tx_req    = tx_req_q;
    assign grant_id_o    = grant_q;
    assign arb_busy_o    = (state_q != S_IDLE);
endmodule
